// File: rtl/lfsr_isa_pkg.sv
// Shared ISA definitions for the LFSR sequenced control unit: opcodes,
// FSM states, the strobe bundle and instruction field-position helpers.
package lfsr_isa_pkg;

  typedef enum logic [2:0] {
    OP_ST        = 3'b000,
    OP_LD        = 3'b001,
    OP_INIT_ADDR = 3'b010,
    OP_ADD_ADDR  = 3'b011,
    OP_CONFIG    = 3'b100,
    OP_INIT_L    = 3'b101,
    OP_RUN       = 3'b110,
    OP_HALT      = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_EXEC   = 2'd0,
    S_MEM    = 2'd1,
    S_RUN    = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  typedef struct packed {
    logic reg_wr;
    logic add;
    logic lfsr_seed;
    logic lfsr_tap;
    logic lfsr_lmem;
    logic lfsr_run;
    logic mem_wr;
    logic mem_req;
  } ctrl_t;

  // Channel field width; a single-channel build still carries one ch bit.
  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int instr_width(input int imm_w, input int ch_w);
    return 3 + ch_w + imm_w;
  endfunction

  function automatic int ch_lsb(input int imm_w);
    return imm_w;
  endfunction

  function automatic int op_lsb(input int imm_w, input int ch_w);
    return imm_w + ch_w;
  endfunction

  // Opcodes whose ch field selects an LFSR channel and must be range checked.
  function automatic logic uses_channel(input op_e op);
    return (op == OP_LD) || (op == OP_CONFIG) || (op == OP_INIT_L) || (op == OP_RUN);
  endfunction

endpackage

// File: rtl/lfsr_op_decode.sv
// Combinational opcode decoder: maps an instruction word to its issue-cycle
// strobes and one-hot channel, suppressing everything on an out-of-range channel.
module lfsr_op_decode import lfsr_isa_pkg::*; #(
  parameter int NCH = 2,
  parameter int IMM_W = 8,
  localparam int CH_W = ch_width(NCH),
  localparam int INSTR_W = instr_width(IMM_W, CH_W)
) (
  input  logic [INSTR_W-1:0] instr,
  output op_e                op,
  output ctrl_t              ctrl,
  output logic               ch_err,
  output logic [NCH-1:0]     ch_onehot,
  output logic [IMM_W-1:0]   imm
);

  logic [CH_W-1:0]      ch;
  logic [2**CH_W-1:0]   ch_valid;

  assign op  = op_e'(instr[op_lsb(IMM_W, CH_W) +: 3]);
  assign ch  = instr[ch_lsb(IMM_W) +: CH_W];
  assign imm = instr[IMM_W-1:0];

  for (genvar i = 0; i < 2**CH_W; i++) begin : g_valid
    assign ch_valid[i] = (i < NCH);
  end

  // Issue-cycle strobes per opcode, then the channel select and its range check.
  always_comb begin
    ctrl      = '0;
    ch_onehot = '0;
    ch_err    = 1'b0;
    case (op)
      OP_ST: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_wr  = 1'b1;
      end
      OP_LD:        ctrl.mem_req   = 1'b1;
      OP_INIT_ADDR: ctrl.reg_wr    = 1'b1;
      OP_ADD_ADDR: begin
        ctrl.reg_wr = 1'b1;
        ctrl.add    = 1'b1;
      end
      OP_CONFIG:    ctrl.lfsr_tap  = 1'b1;
      OP_INIT_L:    ctrl.lfsr_seed = 1'b1;
      OP_RUN:       ctrl.lfsr_run  = (imm != '0);
      default:      ctrl           = '0;
    endcase
    if (uses_channel(op)) begin
      if (ch_valid[ch]) begin
        for (int i = 0; i < NCH; i++) begin
          ch_onehot[i] = (ch == CH_W'(i));
        end
      end else begin
        ch_err = 1'b1;
        ctrl   = '0;
      end
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequenced control unit for the LFSR datapath: owns the program counter,
// the counted RUN loop, the ST/LD memory handshake and sticky halt/error status.
module lfsr_seq_ctrl import lfsr_isa_pkg::*; #(
  parameter int NCH = 2,
  parameter int IMM_W = 8,
  parameter int LFSR_W = 7,
  parameter int PC_W = 8,
  localparam int CH_W = ch_width(NCH),
  localparam int INSTR_W = instr_width(IMM_W, CH_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               stall,
  input  logic               mem_ack,
  output logic [PC_W-1:0]    pc,
  output logic               reg_wr,
  output logic               add,
  output logic               lfsr_seed,
  output logic               lfsr_tap,
  output logic               lfsr_lmem,
  output logic               lfsr_run,
  output logic [NCH-1:0]     lfsr_ch,
  output logic               mem_req,
  output logic               mem_wr,
  output logic [IMM_W-1:0]   immi,
  output logic [LFSR_W-1:0]  lfsr_taps,
  output logic               halt,
  output logic               err
);

  state_e             state, state_next;
  logic [PC_W-1:0]    pc_next;
  logic [IMM_W-1:0]   cnt, cnt_next;
  logic [INSTR_W-1:0] instr_q, instr_q_next;
  logic               halt_next, err_next;
  logic [INSTR_W-1:0] active;
  op_e                op;
  ctrl_t              dec;
  ctrl_t              ctrl;
  logic               ch_err;
  logic [NCH-1:0]     ch_onehot;
  logic [IMM_W-1:0]   imm;
  logic               mem_done;

  // Multi-cycle ops keep decoding the latched word so the ROM output is free to change.
  assign active   = (state == S_EXEC) ? instr : instr_q;
  assign mem_done = dec.mem_req && mem_ack;

  lfsr_op_decode #(.NCH(NCH), .IMM_W(IMM_W)) u_decode (
    .instr     (active),
    .op        (op),
    .ctrl      (dec),
    .ch_err    (ch_err),
    .ch_onehot (ch_onehot),
    .imm       (imm)
  );

  // State register: FSM state, pc, run counter, latched instruction and sticky flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_EXEC;
      pc      <= '0;
      cnt     <= '0;
      instr_q <= '0;
      halt    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      cnt     <= cnt_next;
      instr_q <= instr_q_next;
      halt    <= halt_next;
      err     <= err_next;
    end
  end

  // Next-state logic: issue in EXEC, wait for ack in MEM, count down in RUN.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    cnt_next     = cnt;
    instr_q_next = instr_q;
    halt_next    = halt;
    err_next     = err;
    case (state)
      S_EXEC: begin
        if (!stall) begin
          if (ch_err) begin
            state_next = S_HALTED;
            halt_next  = 1'b1;
            err_next   = 1'b1;
          end else begin
            case (op)
              OP_ST, OP_LD: begin
                if (mem_ack) begin
                  pc_next = pc + PC_W'(1);
                end else begin
                  instr_q_next = instr;
                  state_next   = S_MEM;
                end
              end
              OP_RUN: begin
                if (imm > IMM_W'(1)) begin
                  instr_q_next = instr;
                  cnt_next     = imm - IMM_W'(1);
                  state_next   = S_RUN;
                end else begin
                  pc_next = pc + PC_W'(1);
                end
              end
              OP_HALT: begin
                state_next = S_HALTED;
                halt_next  = 1'b1;
              end
              default: pc_next = pc + PC_W'(1);
            endcase
          end
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          pc_next    = pc + PC_W'(1);
          state_next = S_EXEC;
        end
      end
      S_RUN: begin
        if (cnt == IMM_W'(1)) begin
          cnt_next   = '0;
          pc_next    = pc + PC_W'(1);
          state_next = S_EXEC;
        end else begin
          cnt_next = cnt - IMM_W'(1);
        end
      end
      default: state_next = S_HALTED;
    endcase
  end

  // Output logic: decoded strobes plus completion pulses, all forced low in reset.
  always_comb begin
    ctrl    = '0;
    lfsr_ch = '0;
    if (reset) begin
      case (state)
        S_EXEC, S_MEM: begin
          if (state == S_MEM || !stall) begin
            ctrl    = dec;
            lfsr_ch = ch_onehot;
            if (mem_done) begin
              ctrl.add = 1'b1;
              if (op == OP_LD) begin
                ctrl.lfsr_seed = 1'b1;
                ctrl.lfsr_lmem = 1'b1;
              end
            end
          end
        end
        S_RUN: begin
          ctrl    = dec;
          lfsr_ch = ch_onehot;
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign reg_wr    = ctrl.reg_wr;
  assign add       = ctrl.add;
  assign lfsr_seed = ctrl.lfsr_seed;
  assign lfsr_tap  = ctrl.lfsr_tap;
  assign lfsr_lmem = ctrl.lfsr_lmem;
  assign lfsr_run  = ctrl.lfsr_run;
  assign mem_req   = ctrl.mem_req;
  assign mem_wr    = ctrl.mem_wr;
  assign immi      = imm;
  assign lfsr_taps = imm[LFSR_W-1:0];

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl (three channels): directed ISA cases
// followed by a randomized instruction stream, checked cycle by cycle against
// a per-instruction model of each op's expected strobe sequence.
module tb_lfsr_seq_ctrl;

  localparam int OP_ST = 0, OP_LD = 1, OP_INIT_ADDR = 2, OP_ADD_ADDR = 3;
  localparam int OP_CONFIG = 4, OP_INIT_L = 5, OP_RUN = 6, OP_HALT = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] instr;
  logic        stall;
  logic        mem_ack;
  logic [7:0]  pc;
  logic        reg_wr, add, lfsr_seed, lfsr_tap, lfsr_lmem, lfsr_run;
  logic [2:0]  lfsr_ch;
  logic        mem_req, mem_wr;
  logic [7:0]  immi;
  logic [6:0]  lfsr_taps;
  logic        halt, err;

  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_pc;
  logic exp_halt, exp_err;
  bit   exp_halted;

  lfsr_seq_ctrl #(.NCH(3), .IMM_W(8), .LFSR_W(7), .PC_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .stall     (stall),
    .mem_ack   (mem_ack),
    .pc        (pc),
    .reg_wr    (reg_wr),
    .add       (add),
    .lfsr_seed (lfsr_seed),
    .lfsr_tap  (lfsr_tap),
    .lfsr_lmem (lfsr_lmem),
    .lfsr_run  (lfsr_run),
    .lfsr_ch   (lfsr_ch),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .immi      (immi),
    .lfsr_taps (lfsr_taps),
    .halt      (halt),
    .err       (err)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected strobes, packed {reg_wr, add, seed, tap, lmem, run, mem_wr, mem_req}.
  function automatic logic [7:0] exp_strobes(input int op, input bit last, input int imm);
    case (op)
      OP_ST:        return {1'b0, last, 4'b0000, 2'b11};
      OP_LD:        return {1'b0, last, last, 1'b0, last, 1'b0, 1'b0, 1'b1};
      OP_INIT_ADDR: return 8'b1000_0000;
      OP_ADD_ADDR:  return 8'b1100_0000;
      OP_CONFIG:    return 8'b0001_0000;
      OP_INIT_L:    return 8'b0010_0000;
      OP_RUN:       return (imm > 0) ? 8'b0000_0100 : 8'b0000_0000;
      default:      return 8'b0000_0000;
    endcase
  endfunction

  // One clock: drive inputs just after posedge, check at negedge, return just after next posedge.
  task automatic run_cycle(input logic [12:0] ins, input logic stl, input logic ack, input logic rst_val,
                           input logic [7:0] exp_s, input logic [2:0] exp_ch,
                           input logic [7:0] exp_imm, input bit chk_imm);
    instr   = ins;
    stall   = stl;
    mem_ack = ack;
    reset   = rst_val;
    @(negedge clk);
    check_output("strobes", 32'({reg_wr, add, lfsr_seed, lfsr_tap, lfsr_lmem, lfsr_run, mem_wr, mem_req}),
                 32'(exp_s));
    check_output("lfsr_ch", 32'(lfsr_ch), 32'(exp_ch));
    check_output("pc", 32'(pc), 32'(exp_pc));
    check_output("halt", 32'(halt), 32'(exp_halt));
    check_output("err", 32'(err), 32'(exp_err));
    if (chk_imm) begin
      check_output("immi", 32'(immi), 32'(exp_imm));
      check_output("lfsr_taps", 32'(lfsr_taps), 32'(exp_imm[6:0]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    run_cycle({3'(OP_INIT_ADDR), 2'd0, 8'hA5}, 1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 8'h00, 1'b0);
    exp_pc     = 8'd0;
    exp_halt   = 1'b0;
    exp_err    = 1'b0;
    exp_halted = 1'b0;
  endtask

  // Issue one instruction and walk through its whole expected lifetime.
  task automatic apply_stimulus(input int op, input int ch, input int imm, input int wait_n,
                                input int stalls, input int reset_at);
    logic [12:0] ins;
    logic [12:0] drv;
    logic [2:0]  chv;
    bit          uses_ch, is_mem, last;
    int          ncyc;
    ins     = {3'(op), 2'(ch), 8'(imm)};
    uses_ch = (op == OP_CONFIG) || (op == OP_INIT_L) || (op == OP_LD) || (op == OP_RUN);
    is_mem  = (op == OP_ST) || (op == OP_LD);
    if (exp_halted) begin
      run_cycle(ins, 1'($urandom), 1'($urandom), 1'b1, 8'h00, 3'b000, 8'h00, 1'b0);
      return;
    end
    for (int s = 0; s < stalls; s++) begin
      run_cycle(ins, 1'b1, 1'($urandom), 1'b1, 8'h00, 3'b000, 8'(imm), 1'b1);
    end
    if (uses_ch && ch >= 3) begin
      run_cycle(ins, 1'b0, 1'b0, 1'b1, 8'h00, 3'b000, 8'(imm), 1'b1);
      exp_halted = 1'b1;
      exp_halt   = 1'b1;
      exp_err    = 1'b1;
      return;
    end
    if (op == OP_HALT) begin
      run_cycle(ins, 1'b0, 1'b0, 1'b1, 8'h00, 3'b000, 8'(imm), 1'b1);
      exp_halted = 1'b1;
      exp_halt   = 1'b1;
      return;
    end
    ncyc = is_mem ? wait_n + 1 : (op == OP_RUN) ? ((imm == 0) ? 1 : imm) : 1;
    chv  = uses_ch ? 3'(1 << ch) : 3'b000;
    for (int c = 0; c < ncyc; c++) begin
      drv  = (c == 0) ? ins : 13'($urandom);
      last = (c == ncyc - 1);
      if (c == reset_at) begin
        run_cycle(drv, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 8'h00, 1'b0);
        exp_pc   = 8'd0;
        exp_halt = 1'b0;
        exp_err  = 1'b0;
        return;
      end
      run_cycle(drv, (c == 0) ? 1'b0 : 1'($urandom), is_mem ? last : 1'($urandom), 1'b1,
                exp_strobes(op, last, imm), chv, 8'(imm), 1'b1);
    end
    exp_pc = exp_pc + 8'd1;
  endtask

  initial begin
    instr      = '0;
    stall      = 1'b0;
    mem_ack    = 1'b0;
    reset      = 1'b0;
    exp_pc     = 8'd0;
    exp_halt   = 1'b0;
    exp_err    = 1'b0;
    exp_halted = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    $display("[TB] single-cycle ops");
    apply_stimulus(OP_INIT_ADDR, 0, 8'h12, 0, 0, -1);
    apply_stimulus(OP_ADD_ADDR,  0, 8'h34, 0, 0, -1);
    apply_stimulus(OP_CONFIG,    1, 8'h41, 0, 0, -1);
    apply_stimulus(OP_INIT_L,    0, 8'h3C, 0, 0, -1);
    check_output("pc_after_four", 32'(pc), 32'd4);

    $display("[TB] RUN lengths");
    apply_stimulus(OP_RUN, 0, 5,   0, 0, -1);
    apply_stimulus(OP_RUN, 1, 0,   0, 0, -1);
    apply_stimulus(OP_RUN, 2, 1,   0, 0, -1);
    apply_stimulus(OP_RUN, 2, 255, 0, 0, -1);

    $display("[TB] memory handshake");
    apply_stimulus(OP_ST, 0, 8'h10, 3, 0, -1);
    apply_stimulus(OP_LD, 1, 8'h20, 0, 0, -1);
    apply_stimulus(OP_LD, 2, 8'h30, 2, 0, -1);
    apply_stimulus(OP_INIT_ADDR, 0, 8'h55, 0, 2, -1);

    $display("[TB] reset mid-operation");
    apply_stimulus(OP_RUN, 1, 4, 0, 0, 1);
    apply_stimulus(OP_ST,  0, 8'h77, 3, 0, 1);
    apply_stimulus(OP_LD,  2, 8'h66, 1, 0, -1);

    $display("[TB] random stream");
    for (int n = 0; n < 300; n++) begin
      int op;
      op = $urandom_range(0, 6);
      apply_stimulus(op, $urandom_range(0, 2),
                     (op == OP_RUN) ? $urandom_range(0, 6) : $urandom_range(0, 255),
                     $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, -1);
    end

    $display("[TB] channel error and halt");
    apply_stimulus(OP_CONFIG, 3, 8'h0F, 0, 0, -1);
    apply_stimulus(OP_INIT_ADDR, 0, 8'h01, 0, 0, -1);
    apply_stimulus(OP_RUN, 0, 3, 0, 0, -1);
    apply_reset();
    apply_stimulus(OP_INIT_L, 2, 8'h09, 0, 0, -1);
    apply_stimulus(OP_HALT, 0, 8'h00, 0, 0, -1);
    apply_stimulus(OP_LD, 0, 8'h02, 0, 0, -1);
    apply_stimulus(OP_ADD_ADDR, 0, 8'h03, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
